// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Width of the slice of the operands handled by each pipeline stage.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder over one CW-bit chunk, built from full-adder cells.
module adder_slice
    import adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    // Carry chain; bit 0 is the chunk carry-in, bit CW the chunk carry-out.
    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CW];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CW-bit chunk per stage, carry registered between
// stages, single global advance enable for valid/ready flow control.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Everything a beat carries down the pipe: full operands (b already inverted for
    // subtract), partial sum built chunk by chunk, running carry and the two sign bits.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             sa;
        logic             sb;
    } beat_t;

    beat_t             st_in  [STAGES];
    beat_t             st_nxt [STAGES];
    beat_t             st_q   [STAGES];
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] vld_q;
    logic [CW-1:0]     chunk_s [STAGES];
    logic [STAGES-1:0] chunk_c;
    logic [WIDTH-1:0]  b_eff;
    logic              en;

    // Whole pipe advances together unless a finished result is waiting on the consumer.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;

    // Stage inputs: stage 0 takes the pins, later stages take the previous stage register.
    always_comb begin
        st_in[0].a  = a;
        st_in[0].b  = b_eff;
        st_in[0].s  = '0;
        st_in[0].c  = sub | cin;
        st_in[0].sa = a[WIDTH-1];
        st_in[0].sb = b_eff[WIDTH-1];
        vld_in[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_in[k]  = st_q[k-1];
            vld_in[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(.CW(CW)) u_slice (
            .a    (st_in[k].a[k*CW +: CW]),
            .b    (st_in[k].b[k*CW +: CW]),
            .cin  (st_in[k].c),
            .sum  (chunk_s[k]),
            .cout (chunk_c[k])
        );
    end

    // Each stage drops its chunk result into the partial sum and replaces the carry.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_nxt[k]                = st_in[k];
            st_nxt[k].s[k*CW +: CW]  = chunk_s[k];
            st_nxt[k].c              = chunk_c[k];
        end
    end

    // Stage registers: shift on en; data only reloads behind a valid beat so bubbles
    // leave the last value in place.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (!rst_n) begin
                vld_q[k] <= 1'b0;
                st_q[k]  <= '0;
            end else if (en) begin
                vld_q[k] <= vld_in[k];
                if (vld_in[k]) begin
                    st_q[k] <= st_nxt[k];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = st_q[STAGES-1].s;
    assign carry     = st_q[STAGES-1].c;
    assign overflow  = (st_q[STAGES-1].sa == st_q[STAGES-1].sb) &&
                       (st_q[STAGES-1].s[WIDTH-1] != st_q[STAGES-1].sa);

    // Operands are fully consumed by the last stage.
    logic unused_ops;
    assign unused_ops = ^{st_q[STAGES-1].a, st_q[STAGES-1].b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 16-bit/4-stage unit plus 4-bit units with 2 and 1 stages.
module tb_pipelined_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, carry, overflow;

    logic [1:0]  s_iv, s_ir, s_cin, s_sub, s_ov, s_ordy, s_carry, s_ovf;
    logic [3:0]  s_a [2];
    logic [3:0]  s_b [2];
    logic [3:0]  s_sum [2];

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q16[$];
    exp_t smem [2][1024];

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv[0]), .in_ready(s_ir[0]),
        .a(s_a[0]), .b(s_b[0]), .cin(s_cin[0]), .sub(s_sub[0]), .out_valid(s_ov[0]),
        .out_ready(s_ordy[0]), .sum(s_sum[0]), .carry(s_carry[0]), .overflow(s_ovf[0])
    );

    pipelined_adder #(.WIDTH(4), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv[1]), .in_ready(s_ir[1]),
        .a(s_a[1]), .b(s_b[1]), .cin(s_cin[1]), .sub(s_sub[1]), .out_valid(s_ov[1]),
        .out_ready(s_ordy[1]), .sum(s_sum[1]), .carry(s_carry[1]), .overflow(s_ovf[1])
    );

    // Reference: unsigned result/borrow from plain integer arithmetic, overflow from
    // whether the true signed result fits in w bits.
    function automatic exp_t model(int w, int ua, int ub, bit ci, bit sb);
        int full = 1 << w;
        int half = 1 << (w - 1);
        int uns, sav, sbv, tv;
        exp_t e;
        if (sb) begin
            uns     = ua - ub;
            e.carry = (ua >= ub);
        end else begin
            uns     = ua + ub + int'(ci);
            e.carry = (uns >= full);
        end
        e.sum = 16'(uns & (full - 1));
        sav   = (ua >= half) ? ua - full : ua;
        sbv   = (ub >= half) ? ub - full : ub;
        tv    = sb ? sav - sbv : sav + sbv + int'(ci);
        e.ovf = (tv < -half) || (tv >= half);
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        s_iv = '0; s_ordy = '0; s_cin = '0; s_sub = '0;
        for (int d = 0; d < 2; d++) begin s_a[d] = '0; s_b[d] = '0; end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        q16.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum); end
        n_chk++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (s_ov !== 2'b00 || s_ir !== 2'b11) begin n_fail++; $display("FAIL reset_small: ov %b ir %b want 00 11", s_ov, s_ir); end
    endtask

    // Directed corner values, each checked for exact latency and result.
    task automatic test_directed();
        logic [15:0] va [5];
        logic        vs [5];
        exp_t        e;
        va = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = va[i]; b = 16'h0001; cin = 1'b0; sub = vs[i]; in_valid = 1'b1;
            e = model(16, int'(va[i]), 1, 1'b0, vs[i]);
            @(negedge clk);
            in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~sub; cin = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                n_chk++;
                if (out_valid !== (c == 4)) begin
                    n_fail++; $display("FAIL latency_v%0d_c%0d: out_valid %b want %b", i, c, out_valid, c == 4);
                end
                if (c == 4) begin
                    n_chk++; if (sum !== e.sum) begin n_fail++; $display("FAIL directed_sum_v%0d: got %h want %h", i, sum, e.sum); end
                    n_chk++; if (carry !== e.carry) begin n_fail++; $display("FAIL directed_carry_v%0d: got %b want %b", i, carry, e.carry); end
                    n_chk++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL directed_ovf_v%0d: got %b want %b", i, overflow, e.ovf); end
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
    endtask

    // Eight consecutive beats with the consumer stalled for four cycles mid-stream.
    task automatic test_back_to_back();
        int   sent = 0, got = 0;
        bit   hold_chk = 1'b0;
        exp_t held, obs;
        q16.delete();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 10);
            in_valid  = (sent < 8);
            a = 16'(sent); b = 16'(16'h1000 * sent); cin = 1'b0; sub = 1'b0;
            #1;
            obs = {sum, carry, overflow};
            if (hold_chk) begin
                n_chk++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    n_fail++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, obs, held);
                end
            end
            if (cyc >= 6 && cyc < 10) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: cyc %0d got %b want 0", cyc, in_ready); end
            end
            hold_chk = out_valid && !out_ready;
            held = obs;
            if (out_valid && out_ready) begin
                n_chk++;
                if (q16.size() == 0 || obs !== q16[0]) begin
                    n_fail++; $display("FAIL b2b_result_%0d: got %h want %h", got, obs, (q16.size() != 0) ? q16[0] : '0);
                end
                if (q16.size() != 0) void'(q16.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q16.push_back(model(16, sent, (16'h1000 * sent) & 16'hFFFF, 1'b0, 1'b0));
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_chk++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
    endtask

    // Beats in flight are discarded by reset; the next beat still comes out on time.
    task automatic test_reset_flight();
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'(16'h0101 * (i + 1)); b = 16'h0F0F; cin = 1'b1; sub = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0; in_valid = 1'b1; a = 16'h5555; b = 16'h5555;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        q16.delete();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_out_valid: got %b want 0", out_valid); end
        n_chk++; if (sum !== 16'h0) begin n_fail++; $display("FAIL rstfl_sum: got %h want 0000", sum); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfl_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0;
        e = model(16, 16'h1234, 16'h4321, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        for (int c = 1; c <= 4; c++) begin
            n_chk++;
            if (out_valid !== (c == 4)) begin
                n_fail++; $display("FAIL rstfl_latency_c%0d: out_valid %b want %b", c, out_valid, c == 4);
            end
            if (c < 4) @(negedge clk);
        end
        n_chk++; if ({sum, carry, overflow} !== e) begin n_fail++; $display("FAIL rstfl_result: got %h want %h", {sum, carry, overflow}, e); end
        @(negedge clk);
    endtask

    // Random operands with random valid/ready patterns, checked against the FIFO model.
    task automatic test_random16();
        exp_t obs;
        int   got = 0;
        q16.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit drain = (cyc >= 360);
            in_valid  = !drain && ($urandom_range(0, 3) != 0);
            out_ready = drain || ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            #1;
            obs = {sum, carry, overflow};
            if (out_valid && out_ready) begin
                n_chk++;
                if (q16.size() == 0 || obs !== q16[0]) begin
                    n_fail++; $display("FAIL rand16_result_%0d: got %h want %h", got, obs, (q16.size() != 0) ? q16[0] : '0);
                end
                if (q16.size() != 0) void'(q16.pop_front());
                got++;
            end
            if (in_valid && in_ready) q16.push_back(model(16, int'(a), int'(b), cin, sub));
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_chk++; if (q16.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rand16_drain: left %0d want 0", q16.size()); end
    endtask

    // Exhaustive 4-bit operands, cin and sub on the 2-stage and 1-stage units.
    task automatic test_small_exhaustive();
        int   sent [2] = '{0, 0};
        int   got  [2] = '{0, 0};
        exp_t e;
        for (int cyc = 0; cyc < 6000 && (got[0] < 1024 || got[1] < 1024); cyc++) begin
            for (int d = 0; d < 2; d++) begin
                s_ordy[d] = 1'($urandom_range(0, 1));
                s_iv[d]   = (sent[d] < 1024);
                s_a[d]    = 4'(sent[d]);
                s_b[d]    = 4'(sent[d] >> 4);
                s_cin[d]  = 1'(sent[d] >> 8);
                s_sub[d]  = 1'(sent[d] >> 9);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                if (s_ov[d] && s_ordy[d]) begin
                    e = smem[d][got[d] % 1024];
                    n_chk++;
                    if (got[d] >= sent[d] || s_sum[d] !== e.sum[3:0] || s_carry[d] !== e.carry || s_ovf[d] !== e.ovf) begin
                        n_fail++;
                        $display("FAIL small%0d_result_%0d: got %h/%b/%b want %h/%b/%b",
                                 d, got[d], s_sum[d], s_carry[d], s_ovf[d], e.sum[3:0], e.carry, e.ovf);
                    end
                    got[d]++;
                end
                if (s_iv[d] && s_ir[d]) begin
                    smem[d][sent[d]] = model(4, sent[d] & 15, (sent[d] >> 4) & 15,
                                             1'(sent[d] >> 8), 1'(sent[d] >> 9));
                    sent[d]++;
                end
            end
            @(negedge clk);
        end
        s_iv = '0;
        for (int d = 0; d < 2; d++) begin
            n_chk++; if (got[d] != 1024) begin n_fail++; $display("FAIL small%0d_count: got %0d want 1024", d, got[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flight();
        test_random16();
        test_small_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
